fifo_wr_arbiter: RTL and testbench

//   Round-robin write-port arbiter that shares one synchronous FIFO write port between NUM_REQ producers.

---
 rtl/fifo_wr_arbiter.sv | 119 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ valid/ready producers.
// The owner keeps the port for up to MAX_BURST beats; every grant passes through IDLE.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4,
    parameter int ID_WIDTH   = $clog2(NUM_REQ),
    parameter int CNT_WIDTH  = $clog2(MAX_BURST + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_write_en,
    output logic [DATA_WIDTH-1:0]         fifo_write_data,
    output logic                          grant_active,
    output logic [ID_WIDTH-1:0]           grant_id,
    output logic [CNT_WIDTH-1:0]          beat_count
);

    // state | meaning
    // IDLE  | no owner; pick next requester round-robin (no transfer this cycle)
    // BURST | grant_id owns the FIFO write port until burst limit or valid drop
    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic [ID_WIDTH:0]    NUM_REQ_W = (ID_WIDTH + 1)'(NUM_REQ);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = CNT_WIDTH'(MAX_BURST);
    localparam logic [ID_WIDTH-1:0]  LAST_RST  = ID_WIDTH'(NUM_REQ - 1);

    state_t               state, state_next;
    logic [ID_WIDTH-1:0]  last_grant, last_grant_next;
    logic [ID_WIDTH-1:0]  grant_next;
    logic [CNT_WIDTH-1:0] beat_next;
    logic [CNT_WIDTH-1:0] beat_inc;
    logic [ID_WIDTH-1:0]  pick;
    logic [ID_WIDTH:0]    cand;
    logic                 owner_valid;
    logic                 xfer;

    // Walk candidates from farthest to nearest so the nearest valid one after last_grant wins.
    always_comb begin
        pick = '0;
        cand = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = {1'b0, last_grant} + (ID_WIDTH + 1)'(i);
            if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
            if (req_valid[cand[ID_WIDTH-1:0]]) pick = cand[ID_WIDTH-1:0];
        end
    end

    assign owner_valid   = req_valid[grant_id];
    assign grant_active  = (state == BURST);
    assign xfer          = grant_active && owner_valid && !fifo_full;
    assign fifo_write_en = xfer;
    assign beat_inc      = beat_count + CNT_WIDTH'(1);

    always_comb begin
        req_ready       = '0;
        fifo_write_data = '0;
        if (state == BURST) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant_id == ID_WIDTH'(i)) begin
                    req_ready[i]    = !fifo_full;
                    fifo_write_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_comb begin
        state_next      = state;
        grant_next      = grant_id;
        last_grant_next = last_grant;
        beat_next       = beat_count;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    grant_next = pick;
                    beat_next  = '0;
                    state_next = BURST;
                end
            end
            BURST: begin
                if (xfer) begin
                    beat_next = beat_inc;
                    if (beat_inc == CNT_MAX) begin
                        state_next      = IDLE;
                        last_grant_next = grant_id;
                    end
                end else if (!owner_valid) begin
                    // A dropped valid releases the port even while the FIFO is full.
                    state_next      = IDLE;
                    last_grant_next = grant_id;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_grant <= LAST_RST;
            beat_count <= '0;
        end else begin
            state      <= state_next;
            grant_id   <= grant_next;
            last_grant <= last_grant_next;
            beat_count <= beat_next;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-cycle vectors with hand-derived expected outputs.
// Producer i drives data {i, word} so the written word also identifies its owner.
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 32;
    localparam int MAX_BURST  = 4;
    localparam int ID_WIDTH   = 2;
    localparam int CNT_WIDTH  = 3;

    logic                          clk;
    logic                          rst_n;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full;
    logic                          fifo_write_en;
    logic [DATA_WIDTH-1:0]         fifo_write_data;
    logic                          grant_active;
    logic [ID_WIDTH-1:0]           grant_id;
    logic [CNT_WIDTH-1:0]          beat_count;
    logic [23:0]                   word;

    int n_checks = 0;
    int n_errors = 0;

    fifo_wr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_WIDTH(DATA_WIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .fifo_full      (fifo_full),
        .fifo_write_en  (fifo_write_en),
        .fifo_write_data(fifo_write_data),
        .grant_active   (grant_active),
        .grant_id       (grant_id),
        .beat_count     (beat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        req_data = '0;
        for (int i = 0; i < NUM_REQ; i++)
            req_data[i*DATA_WIDTH +: DATA_WIDTH] = {8'(i), word};
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_wen"},  64'(fifo_write_en),   64'(0));
        check_val({tag, "_rdy"},  64'(req_ready),       64'(0));
        check_val({tag, "_data"}, 64'(fifo_write_data), 64'(0));
        check_val({tag, "_act"},  64'(grant_active),    64'(0));
    endtask

    // Apply inputs after a rising edge, check the combinational/registered view, then clock.
    task automatic step(input string tag, input logic [3:0] valid, input logic full,
                        input logic [23:0] w, input logic exp_wen, input logic [3:0] exp_rdy,
                        input logic exp_act, input logic [1:0] exp_id, input logic [2:0] exp_bc);
        logic [31:0] exp_data;
        req_valid = valid;
        fifo_full = full;
        word      = w;
        #1;
        exp_data = exp_act ? {6'b0, exp_id, w} : 32'h0;
        check_val({tag, "_wen"},  64'(fifo_write_en),   64'(exp_wen));
        check_val({tag, "_rdy"},  64'(req_ready),       64'(exp_rdy));
        check_val({tag, "_act"},  64'(grant_active),    64'(exp_act));
        check_val({tag, "_id"},   64'(grant_id),        64'(exp_id));
        check_val({tag, "_bc"},   64'(beat_count),      64'(exp_bc));
        check_val({tag, "_data"}, 64'(fifo_write_data), 64'(exp_data));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        fifo_full = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int g;
        logic [1:0] prev_id;
        logic [2:0] prev_bc;
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        fifo_full = 1'b0;
        word      = 24'h0;

        // Reset held with all producers requesting: everything quiet.
        repeat (2) @(posedge clk);
        #2;
        check_idle_outputs("rst");
        check_val("rst_id", 64'(grant_id),   64'(0));
        check_val("rst_bc", 64'(beat_count), 64'(0));
        rst_n = 1'b1;
        step("t1_idle", 4'b1111, 1'b0, 24'h0, 1'b0, 4'b0000, 1'b0, 2'd0, 3'd0);
        step("t1_gnt",  4'b1111, 1'b0, 24'h1, 1'b1, 4'b0001, 1'b1, 2'd0, 3'd0);

        // Single producer 2 with six words: burst of 4, bubble, regrant, 2 more, valid drop.
        do_reset();
        step("t2_c0", 4'b0100, 1'b0, 24'hA0, 1'b0, 4'b0000, 1'b0, 2'd0, 3'd0);
        step("t2_c1", 4'b0100, 1'b0, 24'hA0, 1'b1, 4'b0100, 1'b1, 2'd2, 3'd0);
        step("t2_c2", 4'b0100, 1'b0, 24'hA1, 1'b1, 4'b0100, 1'b1, 2'd2, 3'd1);
        step("t2_c3", 4'b0100, 1'b0, 24'hA2, 1'b1, 4'b0100, 1'b1, 2'd2, 3'd2);
        step("t2_c4", 4'b0100, 1'b0, 24'hA3, 1'b1, 4'b0100, 1'b1, 2'd2, 3'd3);
        step("t2_c5", 4'b0100, 1'b0, 24'hA4, 1'b0, 4'b0000, 1'b0, 2'd2, 3'd4);
        step("t2_c6", 4'b0100, 1'b0, 24'hA4, 1'b1, 4'b0100, 1'b1, 2'd2, 3'd0);
        step("t2_c7", 4'b0100, 1'b0, 24'hA5, 1'b1, 4'b0100, 1'b1, 2'd2, 3'd1);
        step("t2_c8", 4'b0000, 1'b0, 24'hA6, 1'b0, 4'b0100, 1'b1, 2'd2, 3'd2);
        step("t2_c9", 4'b0000, 1'b0, 24'hA6, 1'b0, 4'b0000, 1'b0, 2'd2, 3'd2);

        // All valid: grants 0,1,2,3,0 with four beats each and one IDLE bubble between.
        do_reset();
        prev_id = 2'd0;
        prev_bc = 3'd0;
        for (int r = 0; r < 5; r++) begin
            g = r % NUM_REQ;
            step("t3_idle", 4'b1111, 1'b0, 24'(r * 16), 1'b0, 4'b0000, 1'b0, prev_id, prev_bc);
            for (int b = 0; b < MAX_BURST; b++)
                step("t3_beat", 4'b1111, 1'b0, 24'(r * 16 + b + 1), 1'b1, 4'(1 << g),
                     1'b1, 2'(g), 3'(b));
            prev_id = 2'(g);
            prev_bc = 3'd4;
        end

        // FIFO full for three cycles after beat 2: port held, count frozen.
        do_reset();
        step("t4_c0", 4'b0001, 1'b0, 24'h40, 1'b0, 4'b0000, 1'b0, 2'd0, 3'd0);
        step("t4_c1", 4'b0001, 1'b0, 24'h41, 1'b1, 4'b0001, 1'b1, 2'd0, 3'd0);
        step("t4_c2", 4'b0001, 1'b0, 24'h42, 1'b1, 4'b0001, 1'b1, 2'd0, 3'd1);
        step("t4_f0", 4'b0001, 1'b1, 24'h43, 1'b0, 4'b0000, 1'b1, 2'd0, 3'd2);
        step("t4_f1", 4'b0001, 1'b1, 24'h43, 1'b0, 4'b0000, 1'b1, 2'd0, 3'd2);
        step("t4_f2", 4'b0001, 1'b1, 24'h43, 1'b0, 4'b0000, 1'b1, 2'd0, 3'd2);
        step("t4_c6", 4'b0001, 1'b0, 24'h43, 1'b1, 4'b0001, 1'b1, 2'd0, 3'd2);
        step("t4_c7", 4'b0001, 1'b0, 24'h44, 1'b1, 4'b0001, 1'b1, 2'd0, 3'd3);
        step("t4_c8", 4'b0001, 1'b0, 24'h45, 1'b0, 4'b0000, 1'b0, 2'd0, 3'd4);

        // Owner 0 drops valid after one beat while 3 waits: ends at count 1, then 3 granted.
        do_reset();
        step("t5_c0", 4'b1001, 1'b0, 24'h50, 1'b0, 4'b0000, 1'b0, 2'd0, 3'd0);
        step("t5_c1", 4'b1001, 1'b0, 24'h51, 1'b1, 4'b0001, 1'b1, 2'd0, 3'd0);
        step("t5_c2", 4'b1000, 1'b0, 24'h52, 1'b0, 4'b0001, 1'b1, 2'd0, 3'd1);
        step("t5_c3", 4'b1000, 1'b0, 24'h53, 1'b0, 4'b0000, 1'b0, 2'd0, 3'd1);
        step("t5_c4", 4'b1000, 1'b0, 24'h54, 1'b1, 4'b1000, 1'b1, 2'd3, 3'd0);

        // Asynchronous reset in the middle of a burst, then priority restarts at producer 0.
        do_reset();
        step("t6_c0", 4'b0010, 1'b0, 24'h60, 1'b0, 4'b0000, 1'b0, 2'd0, 3'd0);
        step("t6_c1", 4'b0010, 1'b0, 24'h61, 1'b1, 4'b0010, 1'b1, 2'd1, 3'd0);
        step("t6_c2", 4'b0010, 1'b0, 24'h62, 1'b1, 4'b0010, 1'b1, 2'd1, 3'd1);
        req_valid = 4'b1111;
        #1;
        check_val("t6_pre_bc", 64'(beat_count), 64'(2));
        rst_n = 1'b0;
        #1;
        check_idle_outputs("t6_arst");
        check_val("t6_arst_id", 64'(grant_id),   64'(0));
        check_val("t6_arst_bc", 64'(beat_count), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("t6_idle", 4'b1111, 1'b0, 24'h70, 1'b0, 4'b0000, 1'b0, 2'd0, 3'd0);
        step("t6_gnt",  4'b1111, 1'b0, 24'h71, 1'b1, 4'b0001, 1'b1, 2'd0, 3'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
